fft_stage_sequencer: RTL and testbench

Sequencer for the in-place radix-2 DIT FFT datapath. It walks all log2(N) stages of N/2 butterflies and drives the ping-pong bank RAM interface: read/write address pairs, `bank_select`, and write enable. It also supplies the twiddle-ROM address and butterfly-valid strobe. It sits between the top-level start/done handshake and the bank RAM interface plus butterfly pipeline.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_addr_gen.sv | 32 +++
 rtl/fft_stage_sequencer.sv | 125 ++++++++++++
 tb/tb_fft_stage_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT sequencer types, derivation helpers and address widths
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    FLIP,
    DONE
  } fft_state_t;

  function automatic int log2n_of(input int n);
    return $clog2(n);
  endfunction

  function automatic int pipe_of(input int rd_lat, input int bfly_lat);
    return rd_lat + bfly_lat;
  endfunction

  localparam int FFT_N        = 32;
  localparam int FFT_RD_LAT   = 1;
  localparam int FFT_BFLY_LAT = 2;
  localparam int FFT_AW       = log2n_of(FFT_N);
  localparam int FFT_TW       = FFT_AW - 1;

endpackage

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - maps (stage, butterfly index) to the in-place read pair and twiddle index
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_AW
) (
  input  logic [LOG2N-1:0] stage,
  input  logic [LOG2N-2:0] j,
  output logic [LOG2N-1:0] addr1,
  output logic [LOG2N-1:0] addr2,
  output logic [LOG2N-2:0] twiddle
);

  logic [LOG2N-1:0] jx;
  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] k;
  logic [LOG2N-1:0] grp;
  logic [LOG2N-1:0] shamt;

  always_comb begin
    jx    = {1'b0, j};
    half  = LOG2N'(1) << stage;
    k     = jx & (half - LOG2N'(1));
    grp   = jx >> stage;
    addr1 = ((grp << stage) << 1) | k;
    addr2 = addr1 + half;
    // k < half, so the twiddle index never overflows its narrower width
    shamt   = LOG2N'(LOG2N - 1) - stage;
    twiddle = k[LOG2N-2:0] << shamt;
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - radix-2 DIT stage/butterfly sequencer with ping-pong bank control
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N        = FFT_N,
  parameter int RD_LAT   = FFT_RD_LAT,
  parameter int BFLY_LAT = FFT_BFLY_LAT,
  localparam int LOG2N   = log2n_of(N),
  localparam int PIPE    = pipe_of(RD_LAT, BFLY_LAT),
  localparam int AW      = LOG2N,
  localparam int TW      = LOG2N - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          bank_select,
  output logic [AW-1:0] rd_address1,
  output logic [AW-1:0] rd_address2,
  output logic          rd_valid,
  output logic [TW-1:0] twiddle_address,
  output logic [AW-1:0] wr_address1,
  output logic [AW-1:0] wr_address2,
  output logic          wr_en,
  output logic [AW-1:0] stage
);

  localparam int JW = LOG2N - 1;
  localparam int DW = $clog2(PIPE + 1);

  fft_state_t    state;
  logic [JW-1:0] j;
  logic [DW-1:0] dcnt;

  logic [AW-1:0] gen_a1;
  logic [AW-1:0] gen_a2;
  logic [TW-1:0] gen_tw;

  logic          sr_v  [PIPE];
  logic [AW-1:0] sr_a1 [PIPE];
  logic [AW-1:0] sr_a2 [PIPE];

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .stage   (stage),
    .j       (j),
    .addr1   (gen_a1),
    .addr2   (gen_a2),
    .twiddle (gen_tw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      stage       <= '0;
      j           <= '0;
      dcnt        <= '0;
      bank_select <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state       <= RUN;
          stage       <= '0;
          j           <= '0;
          bank_select <= 1'b0;
        end
        RUN: if (j == JW'(N/2 - 1)) begin
          state <= DRAIN;
          dcnt  <= '0;
        end else begin
          j <= j + JW'(1);
        end
        DRAIN: if (dcnt == DW'(PIPE - 1)) begin
          state <= FLIP;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
        FLIP: begin
          bank_select <= ~bank_select;
          if (stage != AW'(LOG2N - 1)) begin
            stage <= stage + AW'(1);
            j     <= '0;
            state <= RUN;
          end else begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign rd_valid        = (state == RUN);
  assign rd_address1     = rd_valid ? gen_a1 : '0;
  assign rd_address2     = rd_valid ? gen_a2 : '0;
  assign twiddle_address = rd_valid ? gen_tw : '0;

  // Write-back rides the read pair through a PIPE-deep tagged delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) begin
        sr_v[i]  <= 1'b0;
        sr_a1[i] <= '0;
        sr_a2[i] <= '0;
      end
    end else begin
      sr_v[0]  <= rd_valid;
      sr_a1[0] <= rd_address1;
      sr_a2[0] <= rd_address2;
      for (int i = 1; i < PIPE; i++) begin
        sr_v[i]  <= sr_v[i-1];
        sr_a1[i] <= sr_a1[i-1];
        sr_a2[i] <= sr_a2[i-1];
      end
    end
  end

  assign wr_en       = sr_v[PIPE-1];
  assign wr_address1 = sr_a1[PIPE-1];
  assign wr_address2 = sr_a2[PIPE-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - directed scoreboard bench for fft_stage_sequencer
module tb_fft_stage_sequencer;

  localparam int N         = 32;
  localparam int LOG2N     = 5;
  localparam int HALFN     = N / 2;
  localparam int PIPE      = 3;
  localparam int STAGE_CYC = HALFN + PIPE + 1;
  localparam int DONE_CYC  = 1 + LOG2N * STAGE_CYC;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, bank_select, rd_valid, wr_en;
  logic [4:0] rd_address1, rd_address2, wr_address1, wr_address2, stage;
  logic [3:0] twiddle_address;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int a1;
    int a2;
  } wr_exp_t;

  wr_exp_t sb[$];

  fft_stage_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .bank_select     (bank_select),
    .rd_address1     (rd_address1),
    .rd_address2     (rd_address2),
    .rd_valid        (rd_valid),
    .twiddle_address (twiddle_address),
    .wr_address1     (wr_address1),
    .wr_address2     (wr_address2),
    .wr_en           (wr_en),
    .stage           (stage)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // j-th address (ascending) whose bit s is clear: the lower leg of butterfly j
  function automatic int nth_addr(input int s, input int j);
    int cnt;
    cnt = 0;
    for (int a = 0; a < N; a++) begin
      if (((a >> s) & 1) == 0) begin
        if (cnt == j) return a;
        cnt++;
      end
    end
    return -1;
  endfunction

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Entered in cycle 1 of a run; leaves in cycle DONE_CYC+1
  task automatic run_full(input bit hold_end);
    int   s, p, a1, h, wr_count, toggles;
    bit   last, exp_rv, exp_bank;
    logic prev_bank;
    wr_count  = 0;
    toggles   = 0;
    prev_bank = 1'b0;
    sb.delete();
    for (int c = 1; c <= DONE_CYC; c++) begin
      s        = (c - 1) / STAGE_CYC;
      p        = (c - 1) % STAGE_CYC;
      last     = (c == DONE_CYC);
      exp_rv   = !last && (p < HALFN);
      exp_bank = last ? 1'b1 : bit'(s % 2);
      chk("ctl", {busy, done, rd_valid, bank_select, stage},
          {1'b1, last, exp_rv, exp_bank, 5'(last ? LOG2N - 1 : s)});
      if (exp_rv) begin
        a1 = nth_addr(s, p);
        h  = 1 << s;
        chk("rd_a1", rd_address1, a1);
        chk("rd_a2", rd_address2, a1 + h);
        chk("twiddle", twiddle_address, (a1 % h) << (LOG2N - 1 - s));
        sb.push_back('{c + PIPE, a1, a1 + h});
      end
      if (sb.size() > 0 && sb[0].cyc == c) begin
        chk("wr_en", wr_en, 1);
        chk("wr_a1", wr_address1, sb[0].a1);
        chk("wr_a2", wr_address2, sb[0].a2);
        wr_count++;
        void'(sb.pop_front());
      end else begin
        chk("wr_en_off", wr_en, 0);
      end
      if (bank_select !== prev_bank) toggles++;
      prev_bank = bank_select;
      // start pulses inside RUN and DONE must be ignored
      start = (c == 5) || (c == DONE_CYC);
      step();
    end
    if (bank_select !== prev_bank) toggles++;
    chk("post_done", {busy, done, rd_valid, wr_en, bank_select}, 5'b00001);
    chk("wr_count", wr_count, 80);
    chk("toggles", toggles, 5);
    chk("sb_empty", sb.size(), 0);
    if (!hold_end) start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    step();
    step();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_bank", bank_select, 0);
    chk("rst_stage", stage, 0);
    chk("rst_rd_a1", rd_address1, 0);
    chk("rst_rd_a2", rd_address2, 0);
    chk("rst_twiddle", twiddle_address, 0);
    chk("rst_wr_a1", wr_address1, 0);
    chk("rst_wr_a2", wr_address2, 0);
    step();
    chk("start_in_rst_ignored", busy, 0);

    launch();
    run_full(1'b0);
    step();
    chk("idle_bank_hold", {busy, bank_select}, 2'b01);

    launch();
    run_full(1'b1);
    step();
    run_full(1'b0);

    launch();
    for (int i = 0; i < 44; i++) step();
    chk("pre_rst_stage", {busy, stage}, {1'b1, 5'd2});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ctl", {busy, done, rd_valid, wr_en, bank_select, stage}, 0);
    for (int i = 0; i < 6; i++) begin
      chk("midrst_no_wr", wr_en, 0);
      step();
    end

    launch();
    run_full(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
